bar_level_tracker: RTL and testbench
====================================

Name: bar_level_tracker

Overview:
- Converts the per-band audio magnitude stream into per-bar heights for the bar-graph renderer.
- Between frames it captures the peak magnitude for each of NUM_BARS bands.
- On each frame boundary (rising edge of VGA_VS) it scales and saturates each peak, applies a peak-fall decay, and commits all heights atomically.
- Sits directly upstream of the bar-graph drawing stage, which reads bar_height_flat.

Parameters:
- NUM_BARS, 10, number of bars/bands.
- MAG_W, 16, width of sample_mag.
- MAG_SHIFT, 6, right shift applied to peak magnitude before saturation.
- MAX_HEIGHT, 479, saturation ceiling for a bar height in pixels.
- DECAY, 8, maximum pixels a bar may fall per frame.

Ports:
- MAX10_CLK1_50  input  1  system clock; all logic in this domain.
- Reset_h  input  1  asynchronous active-high reset.
- VGA_VS  input  1  vertical sync from the VGA controller (asynchronous to this block); rising edge = frame boundary.
- bar_en  input  NUM_BARS  per-bar enable (SW); a disabled bar commits height 0.
- sample_valid  input  1  qualifies sample_band/sample_mag for one cycle.
- sample_band  input  4  band index of the sample.
- sample_mag  input  MAG_W  unsigned magnitude.
- bar_height_flat  output  NUM_BARS*10  committed heights; bar i at bits [10i+9:10i].
- update_done  output  1  one-cycle pulse on the commit cycle.
- drop_cnt  output  8  saturating count of samples with sample_band >= NUM_BARS.

Behaviour:
- Reset (async, Reset_h=1): all accumulators, shadow heights, bar_height_flat, drop_cnt and update_done = 0; FSM = IDLE; synchronizer flops = 0.
- VGA_VS passes through a 2-flop synchronizer plus an edge register. frame_tick asserts one cycle on the synchronized 0->1 transition, 3 clocks after the input edge.
- Accumulate (every state): on sample_valid with band b < NUM_BARS, acc[b] <= max(acc[b], sample_mag).
- Out-of-range band: sample dropped; drop_cnt increments, holding at 255.
- FSM IDLE: on frame_tick, go to UPDATE with idx = 0.
- FSM UPDATE: one bar per cycle, idx 0..NUM_BARS-1.
  - scaled = acc[idx] >> MAG_SHIFT, saturated to MAX_HEIGHT.
  - fallen = old > DECAY ? old - DECAY : 0, where old is bar idx of bar_height_flat.
  - shadow[idx] <= bar_en[idx] ? max(scaled, fallen) : 0.
  - acc[idx] cleared in the same cycle.
  - Simultaneous sample_valid for band idx: acc[idx] <= sample_mag (the new sample starts the next frame's peak; it is not lost).
  - After idx = NUM_BARS-1, go to COMMIT.
- FSM COMMIT (1 cycle): bar_height_flat <= all shadow values at once; update_done = 1; go to IDLE.
- Timing: total latency frame_tick -> update_done is NUM_BARS+1 cycles. Outputs never show a partially updated frame.
- frame_tick during UPDATE/COMMIT is ignored (no queueing).
- Reset mid-UPDATE: everything returns to reset values immediately; no commit.
- Arithmetic: all comparisons unsigned; the shift happens before saturation; heights are always <= MAX_HEIGHT.

Test Plan:
- Reset, then VGA_VS rising edge with no samples -> update_done pulses 14 cycles after the edge (3 sync + 11 FSM); all heights 0.
- bar_en=0x3FF; samples band 2: mag 1000, 6400, 3000; VS edge -> bar2 = 100, others 0. Next frame with no samples -> bar2 = 92, then 84, 76.
- Sample band 5 mag 0xFFFF -> bar5 = 479 (saturated). Band 12 sample -> drop_cnt = 1, no height change. 300 bad samples -> drop_cnt = 255.
- bar_en[3]=0 with band 3 mag 6400 -> bar3 = 0 at commit. The accumulator is still cleared: re-enable with no new samples -> bar3 = 0 next frame.
- Sample band 0 mag 3200 on the exact cycle idx=0 is processed (prior peak 640) -> this frame bar0 = 10; next frame bar0 = 50.
- Assert Reset_h during UPDATE at idx=4 -> no update_done; bar_height_flat = 0 immediately; FSM idle; next VS edge performs a clean update.

Source files
------------

// File: rtl/bar_level_tracker.sv
// -----------------------------------------------------------------------------
// bar_level_tracker
//
// Turns the per-band audio magnitude stream into per-bar heights for the
// bar-graph renderer. Between frames the peak magnitude of each band is
// captured. On each frame boundary (rising edge of VGA_VS), each peak is
// scaled and saturated, and a peak-fall decay is applied. All bar heights are
// then committed at once, so the renderer never sees a half-updated frame.
//
// Ports
//   MAX10_CLK1_50    in   system clock (all logic in this domain)
//   Reset_h          in   asynchronous active-high reset
//   VGA_VS           in   vertical sync, asynchronous; rising edge = frame
//   bar_en           in   [NUM_BARS]   per-bar enable; disabled bar -> 0
//   sample_valid     in   qualifies sample_band / sample_mag for one cycle
//   sample_band      in   [4]          band index of the sample
//   sample_mag       in   [MAG_W]      unsigned magnitude
//   bar_height_flat  out  [NUM_BARS*10] committed heights, bar i at [10i+9:10i]
//   update_done      out  one-cycle pulse, aligned with the commit
//   drop_cnt         out  [8]          saturating count of out-of-range samples
// -----------------------------------------------------------------------------
module bar_level_tracker #(
  parameter int NUM_BARS   = 10,
  parameter int MAG_W      = 16,
  parameter int MAG_SHIFT  = 6,
  parameter int MAX_HEIGHT = 479,
  parameter int DECAY      = 8
) (
  input  logic                     MAX10_CLK1_50,
  input  logic                     Reset_h,
  input  logic                     VGA_VS,
  input  logic [NUM_BARS-1:0]      bar_en,
  input  logic                     sample_valid,
  input  logic [3:0]               sample_band,
  input  logic [MAG_W-1:0]         sample_mag,
  output logic [NUM_BARS*10-1:0]   bar_height_flat,
  output logic                     update_done,
  output logic [7:0]               drop_cnt
);

  localparam int                IDX_W     = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BARS - 1);
  localparam logic [MAG_W-1:0]  MAX_H_MAG = MAG_W'(MAX_HEIGHT);
  localparam logic [9:0]        MAX_H     = 10'(MAX_HEIGHT);
  localparam logic [9:0]        DECAY_H   = 10'(DECAY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_COMMIT
  } state_t;

  // ---------------------------------------------------------------------------
  // VGA_VS synchronizer and rising-edge detect
  // ---------------------------------------------------------------------------
  logic vs_meta;
  logic vs_sync;
  logic vs_prev;
  logic frame_tick;

  // NOTE: clocked state is always written with non-blocking (<=) so every
  // flop samples the pre-edge value of its neighbours; blocking here would
  // collapse the synchronizer chain into a single stage.
  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= VGA_VS;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  // The FSM acts on this at the third clock edge after VGA_VS rises.
  assign frame_tick = vs_sync & ~vs_prev;

  // ---------------------------------------------------------------------------
  // FSM: walks the bars one per cycle, then commits
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              upd_en;
  logic              commit_en;

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    upd_en    = 1'b0;
    commit_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          state_d = S_UPDATE;
          idx_d   = '0;
        end
      end
      S_UPDATE: begin
        upd_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_COMMIT: begin
        commit_en = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Peak accumulators
  // ---------------------------------------------------------------------------
  logic [MAG_W-1:0]    acc [NUM_BARS];
  logic [NUM_BARS-1:0] hit;
  logic [NUM_BARS-1:0] clr;

  always_comb begin
    hit = '0;
    clr = '0;
    for (int i = 0; i < NUM_BARS; i++) begin
      hit[i] = sample_valid && (sample_band == 4'(i));
      clr[i] = upd_en && (idx_q == IDX_W'(i));
    end
  end

  // NOTE: these arrays are small flop banks, not RAM, so they can (and must)
  // be cleared by the async reset; a RAM-mapped array could not be.
  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      for (int i = 0; i < NUM_BARS; i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BARS; i++) begin
        if (clr[i]) begin
          // A sample landing while this bar is being consumed seeds the
          // next frame's peak instead of being lost.
          acc[i] <= hit[i] ? sample_mag : '0;
        end else if (hit[i] && (sample_mag > acc[i])) begin
          acc[i] <= sample_mag;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Out-of-range sample counter
  // ---------------------------------------------------------------------------
  logic band_ok;
  assign band_ok = int'(sample_band) < NUM_BARS;

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      drop_cnt <= '0;
    end else if (sample_valid && !band_ok && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Height datapath for the bar selected by idx_q
  // ---------------------------------------------------------------------------
  logic [9:0]       height_q [NUM_BARS];
  logic [9:0]       shadow   [NUM_BARS];
  logic [MAG_W-1:0] scaled_full;
  logic [9:0]       scaled;
  logic [9:0]       old_h;
  logic [9:0]       fallen;
  logic [9:0]       new_h;

  always_comb begin
    // Shift first, then saturate: the ceiling is in pixels, not magnitude.
    scaled_full = acc[idx_q] >> MAG_SHIFT;
    scaled      = (scaled_full > MAX_H_MAG) ? MAX_H : scaled_full[9:0];
    old_h       = height_q[idx_q];
    fallen      = (old_h > DECAY_H) ? (old_h - DECAY_H) : '0;
    new_h       = bar_en[idx_q] ? ((scaled > fallen) ? scaled : fallen) : '0;
  end

  // Shadow heights fill one bar per cycle; the visible heights only move on
  // the commit edge, together with update_done.
  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      for (int i = 0; i < NUM_BARS; i++) begin
        shadow[i]   <= '0;
        height_q[i] <= '0;
      end
      update_done <= 1'b0;
    end else begin
      update_done <= commit_en;
      if (upd_en) shadow[idx_q] <= new_h;
      if (commit_en) begin
        for (int i = 0; i < NUM_BARS; i++) height_q[i] <= shadow[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_BARS; g++) begin : g_flat
    assign bar_height_flat[g*10 +: 10] = height_q[g];
  end

endmodule

// File: tb/tb_bar_level_tracker.sv
// -----------------------------------------------------------------------------
// tb_bar_level_tracker
//
// Directed bench for bar_level_tracker. A behavioural model predicts each
// frame's heights when the VGA_VS edge is driven; the prediction is queued
// and compared when update_done appears. Spot checks on individual bars use
// literal pixel values.
// -----------------------------------------------------------------------------
module tb_bar_level_tracker;

  localparam int NB = 10;
  localparam int FW = NB * 10;

  logic           clk;
  logic           rst;
  logic           vga_vs;
  logic [NB-1:0]  bar_en;
  logic           sample_valid;
  logic [3:0]     sample_band;
  logic [15:0]    sample_mag;
  logic [FW-1:0]  bar_height_flat;
  logic           update_done;
  logic [7:0]     drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] exp_q [$];

  // Model state
  int mac [NB];
  int mh  [NB];

  bar_level_tracker dut (
    .MAX10_CLK1_50   (clk),
    .Reset_h         (rst),
    .VGA_VS          (vga_vs),
    .bar_en          (bar_en),
    .sample_valid    (sample_valid),
    .sample_band     (sample_band),
    .sample_mag      (sample_mag),
    .bar_height_flat (bar_height_flat),
    .update_done     (update_done),
    .drop_cnt        (drop_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] bar(input int i);
    return bar_height_flat[i*10 +: 10];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      mac[i] = 0;
      mh[i]  = 0;
    end
  endtask

  task automatic model_sample(input int b, input int m);
    if (b < NB && m > mac[b]) mac[b] = m;
  endtask

  task automatic model_frame(output logic [FW-1:0] r);
    int s, f;
    for (int i = 0; i < NB; i++) begin
      s = mac[i] / 64;
      if (s > 479) s = 479;
      f = (mh[i] > 8) ? mh[i] - 8 : 0;
      mh[i] = bar_en[i] ? ((s > f) ? s : f) : 0;
      mac[i] = 0;
      r[i*10 +: 10] = 10'(mh[i]);
    end
  endtask

  task automatic send(input int b, input int m);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_band  = 4'(b);
    sample_mag   = 16'(m);
    @(negedge clk);
    sample_valid = 1'b0;
    model_sample(b, m);
  endtask

  // Drive one frame edge; optionally inject a sample in the cycle that
  // follows the inj_at-th clock edge after VGA_VS rises.
  task automatic frame(input string tag, input int inj_at, input int inj_band, input int inj_mag);
    logic [FW-1:0] e;
    logic [FW-1:0] got;
    bit seen;
    int n;
    model_frame(e);
    exp_q.push_back(e);
    if (inj_at >= 0) model_sample(inj_band, inj_mag);
    @(negedge clk);
    vga_vs = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (update_done) begin
        seen = 1;
      end else begin
        @(negedge clk);
        if (n == inj_at) begin
          sample_valid = 1'b1;
          sample_band  = 4'(inj_band);
          sample_mag   = 16'(inj_mag);
        end else begin
          sample_valid = 1'b0;
        end
      end
    end
    sample_valid = 1'b0;
    check({tag, "_done_seen"}, 128'(seen), 128'(1));
    got = exp_q.pop_front();
    if (seen) begin
      check({tag, "_latency"}, 128'(n), 128'(14));
      check({tag, "_heights"}, 128'(bar_height_flat), 128'(got));
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, 128'(update_done), 128'(0));
    end
    @(negedge clk);
    vga_vs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int stray;
    rst          = 1'b1;
    vga_vs       = 1'b0;
    bar_en       = '0;
    sample_valid = 1'b0;
    sample_band  = '0;
    sample_mag   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_heights", 128'(bar_height_flat), 128'(0));
    check("rst_done", 128'(update_done), 128'(0));
    check("rst_drop", 128'(drop_cnt), 128'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Empty frame
    bar_en = 10'h3FF;
    frame("empty", -1, 0, 0);
    check("empty_all_zero", 128'(bar_height_flat), 128'(0));

    // Peak capture on band 2, then decay
    send(2, 1000);
    send(2, 6400);
    send(2, 3000);
    frame("peak", -1, 0, 0);
    check("bar2_peak", 128'(bar(2)), 128'(100));
    frame("decay1", -1, 0, 0);
    check("bar2_decay1", 128'(bar(2)), 128'(92));
    frame("decay2", -1, 0, 0);
    check("bar2_decay2", 128'(bar(2)), 128'(84));
    frame("decay3", -1, 0, 0);
    check("bar2_decay3", 128'(bar(2)), 128'(76));

    // Saturation
    send(5, 16'hFFFF);
    frame("sat", -1, 0, 0);
    check("bar5_sat", 128'(bar(5)), 128'(479));

    // Out-of-range band
    send(12, 5000);
    check("drop_one", 128'(drop_cnt), 128'(1));
    frame("drop_frame", -1, 0, 0);
    check("bar5_after_drop", 128'(bar(5)), 128'(471));
    for (int i = 0; i < 300; i++) send(10 + (i % 6), i);
    check("drop_sat", 128'(drop_cnt), 128'(255));

    // Disabled bar still clears its accumulator
    bar_en = 10'h3F7;
    send(3, 6400);
    frame("disabled", -1, 0, 0);
    check("bar3_disabled", 128'(bar(3)), 128'(0));
    bar_en = 10'h3FF;
    frame("reenabled", -1, 0, 0);
    check("bar3_reenabled", 128'(bar(3)), 128'(0));

    // Sample arriving in the same cycle its bar is consumed
    send(0, 640);
    frame("idx0_hit", 3, 0, 3200);
    check("bar0_this_frame", 128'(bar(0)), 128'(10));
    frame("idx0_next", -1, 0, 0);
    check("bar0_next_frame", 128'(bar(0)), 128'(50));

    // Reset in the middle of UPDATE (idx = 4)
    @(negedge clk);
    vga_vs = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_heights", 128'(bar_height_flat), 128'(0));
    check("midrst_done", 128'(update_done), 128'(0));
    check("midrst_drop", 128'(drop_cnt), 128'(0));
    vga_vs = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (update_done) stray++;
    end
    check("midrst_no_commit", 128'(stray), 128'(0));
    check("midrst_still_zero", 128'(bar_height_flat), 128'(0));
    send(7, 3200);
    frame("post_rst", -1, 0, 0);
    check("bar7_post_rst", 128'(bar(7)), 128'(50));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
